// File: rtl/axi4l_gpio_slave.sv
// axi4l_gpio_slave -- AXI4-Lite slave exposing a small GPIO register file.
//
// Register map (word index = ADDR[4:2], all other address bits ignored):
//   0 DATA_OUT (RW)   1 DIR (RW, 1 = output)   2 DATA_IN (RO, synchronized pins)
//   3 IRQ_EN (RW)     4 IRQ_STAT (W1C)         5..7 unmapped -> SLVERR, read 0
//
// Optional feature macro: GPIO_IRQ_EN
//   Defined    : rising-edge interrupts, IRQ_EN/IRQ_STAT mapped, registered irq.
//   Undefined  : IRQ_EN/IRQ_STAT behave as unmapped, no edge logic, irq = 0.
module axi4l_gpio_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int GPIO_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  input  logic [GPIO_WIDTH-1:0]     gpio_in,
  output logic [GPIO_WIDTH-1:0]     gpio_out,
  output logic [GPIO_WIDTH-1:0]     gpio_oe,
  output logic                      irq
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] IDX_DATA_OUT = 3'd0;
  localparam logic [2:0] IDX_DIR      = 3'd1;
  localparam logic [2:0] IDX_DATA_IN  = 3'd2;
`ifdef GPIO_IRQ_EN
  localparam logic [2:0] IDX_IRQ_EN   = 3'd3;
  localparam logic [2:0] IDX_IRQ_STAT = 3'd4;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Expand byte strobes into a per-bit write mask.
  function automatic logic [DATA_WIDTH-1:0] strb_to_mask(input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] mask;
    mask = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < STRB_WIDTH; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

  // Write channel state
  logic                    aw_held_r;
  logic [2:0]              aw_idx_r;
  logic                    w_held_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [STRB_WIDTH-1:0]   wstrb_r;
  logic                    bvalid_r;
  logic [1:0]              bresp_r;

  // Read channel state
  logic                    rvalid_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
  logic [1:0]              rresp_r;

  // Register file and input synchronizer
  logic [GPIO_WIDTH-1:0]   data_out_r;
  logic [GPIO_WIDTH-1:0]   dir_r;
  logic [GPIO_WIDTH-1:0]   sync1_r;
  logic [GPIO_WIDTH-1:0]   sync2_r;

  // Handshakes and selected write operands
  logic                    awready_s;
  logic                    wready_s;
  logic                    arready_s;
  logic                    aw_hs_s;
  logic                    w_hs_s;
  logic                    ar_hs_s;
  logic                    wr_fire_s;
  logic [2:0]              wr_idx_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic [STRB_WIDTH-1:0]   wr_strb_s;
  logic [DATA_WIDTH-1:0]   wr_mask_s;
  logic [GPIO_WIDTH-1:0]   wr_bits_s;
  logic [GPIO_WIDTH-1:0]   wr_bmask_s;
  logic [1:0]              wr_resp_s;
  logic [GPIO_WIDTH-1:0]   data_out_nxt_s;
  logic [GPIO_WIDTH-1:0]   dir_nxt_s;

  // Read decode
  logic [2:0]              rd_idx_s;
  logic [GPIO_WIDTH-1:0]   rd_gpio_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;
  logic [1:0]              rd_resp_s;

  // Collects address/data bits that the decode intentionally ignores.
  logic                    unused_s;

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0]   irq_en_r;
  logic [GPIO_WIDTH-1:0]   irq_stat_r;
  logic [GPIO_WIDTH-1:0]   sync_d_r;
  logic                    irq_r;
  logic [GPIO_WIDTH-1:0]   irq_en_nxt_s;
  logic [GPIO_WIDTH-1:0]   stat_clr_s;
  logic [GPIO_WIDTH-1:0]   stat_set_s;
  logic [GPIO_WIDTH-1:0]   irq_stat_nxt_s;
`endif

  // A channel accepts a new beat only while nothing is latched and no response is pending.
  assign awready_s = ~aw_held_r & ~bvalid_r;
  assign wready_s  = ~w_held_r & ~bvalid_r;
  assign arready_s = ~rvalid_r;
  assign aw_hs_s   = AWVALID & awready_s;
  assign w_hs_s    = WVALID & wready_s;
  assign ar_hs_s   = ARVALID & arready_s;

  // The write commits on the edge where both address and data are available,
  // whether they were latched earlier or are handshaking right now.
  assign wr_fire_s  = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
  assign wr_idx_s   = aw_held_r ? aw_idx_r : AWADDR[4:2];
  assign wr_data_s  = w_held_r ? wdata_r : WDATA;
  assign wr_strb_s  = w_held_r ? wstrb_r : WSTRB;
  assign wr_mask_s  = strb_to_mask(wr_strb_s);
  assign wr_bits_s  = wr_data_s[GPIO_WIDTH-1:0];
  assign wr_bmask_s = wr_mask_s[GPIO_WIDTH-1:0];
  assign rd_idx_s   = ARADDR[4:2];

  assign unused_s = ^{AWADDR, ARADDR, wr_data_s, wr_mask_s};

  assign AWREADY  = awready_s;
  assign WREADY   = wready_s;
  assign ARREADY  = arready_s;
  assign BVALID   = bvalid_r;
  assign BRESP    = bresp_r;
  assign RVALID   = rvalid_r;
  assign RDATA    = rdata_r;
  assign RRESP    = rresp_r;
  assign gpio_out = data_out_r;
  assign gpio_oe  = dir_r;

  // Write decode: next register values and the response for the committing write.
  always_comb begin
    data_out_nxt_s = data_out_r;
    dir_nxt_s      = dir_r;
    wr_resp_s      = RESP_OKAY;
`ifdef GPIO_IRQ_EN
    irq_en_nxt_s   = irq_en_r;
    stat_clr_s     = {GPIO_WIDTH{1'b0}};
`endif
    if (wr_fire_s) begin
      case (wr_idx_s)
        IDX_DATA_OUT: data_out_nxt_s = (data_out_r & ~wr_bmask_s) | (wr_bits_s & wr_bmask_s);
        IDX_DIR:      dir_nxt_s      = (dir_r & ~wr_bmask_s) | (wr_bits_s & wr_bmask_s);
        IDX_DATA_IN:  wr_resp_s      = RESP_OKAY;
`ifdef GPIO_IRQ_EN
        IDX_IRQ_EN:   irq_en_nxt_s   = (irq_en_r & ~wr_bmask_s) | (wr_bits_s & wr_bmask_s);
        IDX_IRQ_STAT: stat_clr_s     = wr_bits_s & wr_bmask_s;
`endif
        default:      wr_resp_s      = RESP_SLVERR;
      endcase
    end else begin
      wr_resp_s = RESP_OKAY;
    end
  end

  // Read decode: register contents at the AR handshake, so a same-cycle write is not visible.
  always_comb begin
    rd_gpio_s = {GPIO_WIDTH{1'b0}};
    rd_resp_s = RESP_OKAY;
    case (rd_idx_s)
      IDX_DATA_OUT: rd_gpio_s = data_out_r;
      IDX_DIR:      rd_gpio_s = dir_r;
      IDX_DATA_IN:  rd_gpio_s = sync2_r;
`ifdef GPIO_IRQ_EN
      IDX_IRQ_EN:   rd_gpio_s = irq_en_r;
      IDX_IRQ_STAT: rd_gpio_s = irq_stat_r;
`endif
      default:      rd_resp_s = RESP_SLVERR;
    endcase
    rd_data_s = {DATA_WIDTH{1'b0}};
    rd_data_s[GPIO_WIDTH-1:0] = rd_gpio_s;
  end

  // Write channel: latch AW and W independently, commit, then hold B until BREADY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held_r <= 1'b0;
      aw_idx_r  <= 3'd0;
      w_held_r  <= 1'b0;
      wdata_r   <= {DATA_WIDTH{1'b0}};
      wstrb_r   <= {STRB_WIDTH{1'b0}};
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else if (wr_fire_s) begin
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      bvalid_r  <= 1'b1;
      bresp_r   <= wr_resp_s;
    end else begin
      if (aw_hs_s) begin
        aw_held_r <= 1'b1;
        aw_idx_r  <= AWADDR[4:2];
      end
      if (w_hs_s) begin
        w_held_r <= 1'b1;
        wdata_r  <= WDATA;
        wstrb_r  <= WSTRB;
      end
      if (bvalid_r && BREADY) begin
        bvalid_r <= 1'b0;
        bresp_r  <= RESP_OKAY;
      end
    end
  end

  // Read channel: capture data/response at AR handshake, hold until RREADY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
      rresp_r  <= RESP_OKAY;
    end else if (ar_hs_s) begin
      rvalid_r <= 1'b1;
      rdata_r  <= rd_data_s;
      rresp_r  <= rd_resp_s;
    end else if (rvalid_r && RREADY) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
      rresp_r  <= RESP_OKAY;
    end
  end

  // Output data and direction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_r <= {GPIO_WIDTH{1'b0}};
      dir_r      <= {GPIO_WIDTH{1'b0}};
    end else begin
      data_out_r <= data_out_nxt_s;
      dir_r      <= dir_nxt_s;
    end
  end

  // Two-flop synchronizer for the asynchronous pin inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= {GPIO_WIDTH{1'b0}};
      sync2_r <= {GPIO_WIDTH{1'b0}};
    end else begin
      sync1_r <= gpio_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef GPIO_IRQ_EN
  // A fresh rising edge beats a W1C clear of the same bit.
  assign stat_set_s     = sync2_r & ~sync_d_r & irq_en_r;
  assign irq_stat_nxt_s = (irq_stat_r & ~stat_clr_s) | stat_set_s;

  // Interrupt enable/status, edge-detect history and the registered irq line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_en_r   <= {GPIO_WIDTH{1'b0}};
      irq_stat_r <= {GPIO_WIDTH{1'b0}};
      sync_d_r   <= {GPIO_WIDTH{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      irq_en_r   <= irq_en_nxt_s;
      irq_stat_r <= irq_stat_nxt_s;
      sync_d_r   <= sync2_r;
      irq_r      <= |(irq_stat_r & irq_en_r);
    end
  end

  assign irq = irq_r;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_axi4l_gpio_slave.sv
// tb_axi4l_gpio_slave -- randomized AXI4-Lite traffic against a register-map model.
// Honours GPIO_IRQ_EN the same way the design does.
module tb_axi4l_gpio_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [31:0] gpio_oe;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_out, m_dir, m_en, m_stat, m_pins;

  always #5 clk = ~clk;

  axi4l_gpio_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .GPIO_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  // Apply a write to the model; returns the expected BRESP.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] m;
    m = byte_mask(strb);
    case ((addr >> 2) & 32'd7)
      32'd0: m_out = (m_out & ~m) | (data & m);
      32'd1: m_dir = (m_dir & ~m) | (data & m);
      32'd2: ;
`ifdef GPIO_IRQ_EN
      32'd3: m_en = (m_en & ~m) | (data & m);
      32'd4: m_stat = m_stat & ~(data & m);
`endif
      default: return 2'b10;
    endcase
    return 2'b00;
  endfunction

  // Expected {RRESP, RDATA} for a read of addr.
  function automatic logic [33:0] model_read(input logic [31:0] addr);
    case ((addr >> 2) & 32'd7)
      32'd0: return {2'b00, m_out};
      32'd1: return {2'b00, m_dir};
      32'd2: return {2'b00, m_pins};
`ifdef GPIO_IRQ_EN
      32'd3: return {2'b00, m_en};
      32'd4: return {2'b00, m_stat};
`endif
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  function automatic logic model_irq();
`ifdef GPIO_IRQ_EN
    return |(m_stat & m_en);
`else
    return 1'b0;
`endif
  endfunction

  // Drives one write; called at a negedge, returns at a negedge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs, b_hs;
    int last_hs = -1, first_bv = -1, bad = 0;
    logic [1:0] bresp_seen = 2'b00;
    resp = 2'b11;
    for (int c = 0; c < 100 && !b_done; c++) begin
      if (BVALID) begin
        if (first_bv < 0) begin
          first_bv = c;
          bresp_seen = BRESP;
        end else if (BRESP !== bresp_seen) bad++;
        if (AWREADY || WREADY) bad++;
      end
      if (w_done && WREADY) bad++;
      if (aw_done && AWREADY) bad++;
      AWADDR  = addr;
      WDATA   = data;
      WSTRB   = strb;
      AWVALID = !aw_done && c >= aw_dly;
      WVALID  = !w_done && c >= w_dly;
      BREADY  = c >= b_dly;
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      b_hs  = BVALID && BREADY;
      if (b_hs) resp = BRESP;
      if (aw_hs || w_hs) last_hs = c;
      @(negedge clk);
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      b_done  = b_done | b_hs;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b0;
    chk("wr_done", 32'(b_done), 32'd1);
    chk("wr_b_latency", 32'(first_bv), 32'(last_hs + 1));
    chk("wr_protocol", 32'(bad), 32'd0);
  endtask

  // Drives one read; called at a negedge, returns at a negedge.
  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0, ar_hs, r_hs;
    int ar_c = -1, first_rv = -1, bad = 0;
    logic [31:0] d_seen = 32'h0;
    logic [1:0]  r_seen = 2'b00;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    for (int c = 0; c < 100 && !r_done; c++) begin
      if (RVALID) begin
        if (first_rv < 0) begin
          first_rv = c;
          d_seen = RDATA;
          r_seen = RRESP;
        end else if (RDATA !== d_seen || RRESP !== r_seen) bad++;
        if (ARREADY) bad++;
      end
      if (ar_done && ARREADY) bad++;
      ARADDR  = addr;
      ARVALID = !ar_done && c >= ar_dly;
      RREADY  = c >= r_dly;
      ar_hs = ARVALID && ARREADY;
      r_hs  = RVALID && RREADY;
      if (r_hs) begin
        data = RDATA;
        resp = RRESP;
      end
      if (ar_hs) ar_c = c;
      @(negedge clk);
      ar_done = ar_done | ar_hs;
      r_done  = r_done | r_hs;
    end
    ARVALID = 1'b0;
    RREADY  = 1'b0;
    chk("rd_done", 32'(r_done), 32'd1);
    chk("rd_r_latency", 32'(first_rv), 32'(ar_c + 1));
    chk("rd_protocol", 32'(bad), 32'd0);
  endtask

  task automatic check_pins();
    chk("gpio_out", gpio_out, m_out);
    chk("gpio_oe", gpio_oe, m_dir);
    chk("irq", 32'(irq), 32'(model_irq()));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] resp;
    logic [1:0] exp;
    axi_write(addr, data, strb, aw_dly, w_dly, b_dly, resp);
    exp = model_write(addr, data, strb);
    chk("bresp", 32'(resp), 32'(exp));
    check_pins();
  endtask

  task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    logic [31:0] d;
    logic [1:0]  r;
    logic [33:0] exp;
    exp = model_read(addr);
    axi_read(addr, ar_dly, r_dly, d, r);
    chk("rdata", d, exp[31:0]);
    chk("rresp", 32'(r), 32'(exp[33:32]));
  endtask

  // Changes the pins and waits long enough for sync, edge detect and irq to settle.
  task automatic set_pins(input logic [31:0] v);
    gpio_in = v;
`ifdef GPIO_IRQ_EN
    m_stat = m_stat | (v & ~m_pins & m_en);
`endif
    m_pins = v;
    repeat (4) @(negedge clk);
  endtask

  task automatic model_reset();
    m_out = 32'h0; m_dir = 32'h0; m_en = 32'h0; m_stat = 32'h0;
  endtask

  initial begin
    logic [31:0] d, addr, data;
    logic [1:0]  wr, rr;
    logic [33:0] exp;
    int op, idx;

    rst = 1'b0;
    AWADDR = 32'h0; AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = 32'h0; ARVALID = 1'b0; RREADY = 1'b0; gpio_in = 32'h0;
    model_reset();
    m_pins = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_awready", 32'(AWREADY), 32'd1);
    chk("rst_wready", 32'(WREADY), 32'd1);
    chk("rst_arready", 32'(ARREADY), 32'd1);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_resp", 32'({BRESP, RRESP}), 32'd0);
    check_pins();
    rst = 1'b1;
    @(negedge clk);

    // Full write, same-cycle AW+W, then read back
    do_write(32'h0000_0000, 32'hA5A5_0F0F, 4'hF, 0, 0, 0);
    chk("gpio_out_const", gpio_out, 32'hA5A5_0F0F);
    do_read(32'h0000_0000, 0, 0);

    // Byte strobe
    do_write(32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_write(32'h0000_0000, 32'h0000_0000, 4'b0010, 0, 0, 0);
    axi_read(32'h0000_0000, 0, 0, d, rr);
    chk("strobe_const", d, 32'hFFFF_00FF);

    // Decoupled channels: W three cycles ahead of AW, BREADY held off five cycles after BVALID
    do_write(32'h0000_0004, 32'h1234_5678, 4'hF, 3, 0, 9);
    do_read(32'h0000_0004, 1, 2);

    // Input path: read issued two cycles after the pin change
    gpio_in = 32'h0000_0003;
    repeat (2) @(negedge clk);
    axi_read(32'h0000_0008, 0, 0, d, rr);
    chk("data_in_const", d, 32'h0000_0003);
    m_pins = 32'h0000_0003;
    repeat (2) @(negedge clk);

    // Unmapped accesses
    do_write(32'h0000_0018, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(32'h0000_001C, 0, 0, d, rr);
    chk("unmapped_rresp", 32'(rr), 32'd2);
    chk("unmapped_rdata", d, 32'h0);
    for (int i = 0; i < 5; i++) do_read(32'(i * 4), 0, 0);

    // Same-cycle read and write of one register: read sees the old value
    exp = model_read(32'h0);
    fork
      axi_write(32'h0000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, 0, wr);
      axi_read(32'h0000_0000, 0, 0, d, rr);
    join
    chk("rw_same_cycle", d, exp[31:0]);
    chk("rw_bresp", 32'(wr), 32'(model_write(32'h0, 32'h0BAD_F00D, 4'hF)));
    check_pins();

`ifdef GPIO_IRQ_EN
    // Edge interrupt: status 3 cycles after the pin edge, irq one cycle later
    set_pins(32'h0);
    do_write(32'h0000_000C, 32'h0000_0001, 4'hF, 0, 0, 0);
    gpio_in = 32'h0000_0001;
    repeat (3) @(negedge clk);
    chk("irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_set", 32'(irq), 32'd1);
    m_pins = 32'h0000_0001;
    m_stat = 32'h0000_0001;
    do_read(32'h0000_0010, 0, 0);
    do_write(32'h0000_0010, 32'h0000_0002, 4'hF, 0, 0, 0);
    chk("stat_kept", 32'(irq), 32'd1);
    do_write(32'h0000_0010, 32'h0000_0001, 4'hF, 0, 0, 0);
    chk("stat_cleared_irq", 32'(irq), 32'd0);
    do_read(32'h0000_0010, 0, 0);
`else
    do_write(32'h0000_000C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    do_read(32'h0000_000C, 0, 0);
    do_read(32'h0000_0010, 0, 0);
    chk("irq_tied", 32'(irq), 32'd0);
`endif

    // Randomized traffic with aliased addresses
    for (int i = 0; i < 200; i++) begin
      op   = int'($urandom_range(0, 9));
      idx  = int'($urandom_range(0, 7));
      addr = ($urandom() & 32'hFFFF_FFE0) | 32'(idx << 2) | 32'($urandom_range(0, 3));
      data = $urandom();
      if (op <= 3) begin
        do_write(addr, data, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      end else if (op <= 7) begin
        do_read(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else if (op == 8) begin
        set_pins($urandom());
        check_pins();
      end else begin
        exp = model_read(addr);
        fork
          axi_write(addr, data, 4'hF, 0, 0, 0, wr);
          axi_read(addr, 0, 0, d, rr);
        join
        chk("rand_rw_rdata", d, exp[31:0]);
        chk("rand_rw_bresp", 32'(wr), 32'(model_write(addr, data, 4'hF)));
        check_pins();
      end
    end

    // Reset asserted while a read response is pending
    ARADDR = 32'h0000_0000;
    ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    chk("pre_rst_rvalid", 32'(RVALID), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(RVALID), 32'd0);
    chk("mid_rst_gpio_out", gpio_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    chk("post_rst_rvalid", 32'(RVALID), 32'd0);
    for (int i = 0; i < 5; i++) do_read(32'(i * 4), 0, 0);
    check_pins();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
